manchester_tx: RTL and testbench

MANCHESTER_TX -- requirements
Module: manchester_tx

---
 rtl/manchester_tx_pkg.sv | 22 ++
 rtl/manchester_tx_half_bit_tick.sv | 37 +++
 rtl/manchester_tx.sv | 136 +++++++++++++
 tb/tb_manchester_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_tx_pkg.sv
// manchester_tx_pkg
// Shared types and constants for the Manchester transmitter: the frame FSM
// state encoding, field sizes and the line-level encoding helper.
package manchester_tx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      DATA = 2'd2,
      STOP = 2'd3
   } state_t;

   localparam int BITS_PER_FIELD = 8;
   localparam int STOP_HALVES    = 4;

   // IEEE 802.3 Manchester: the second half of a bit carries the bit value and
   // the first half carries its complement (1 = low->high, 0 = high->low).
   function automatic logic line_level(input logic bit_val, input logic phase);
      return phase ? bit_val : ~bit_val;
   endfunction

endpackage

// File: rtl/manchester_tx_half_bit_tick.sv
// half_bit_tick
// Half-bit timebase. While en_i is high the counter runs 0..DIV-1 and wraps,
// pulsing tick_o for one cycle on the DIV-1 count. While en_i is low the
// counter is held at 0, so the first tick after enabling comes exactly DIV
// cycles later.
// Ports:
//   clk_i  - system clock, rising edge
//   rst_i  - synchronous active-high reset
//   en_i   - run the counter
//   tick_o - one-cycle strobe at the end of each half-bit
module half_bit_tick #(
   parameter int DIV = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/manchester_tx.sv
// manchester_tx
// Byte-wide Manchester transmitter. Each accepted byte goes out as a frame:
// 8 preamble bits, 8 data bits (both MSB first), then 4 low half-bits of
// stop. Each half-bit lasts DIV clock cycles.
// Ports:
//   clk_i   - system clock, rising edge
//   rst_i   - synchronous active-high reset; aborts a frame in progress
//   data_i  - byte to transmit
//   valid_i - data_i is valid
//   ready_o - the block accepts a byte this cycle (IDLE only)
//   tx_o    - registered Manchester line output
//   busy_o  - registered, high while a frame is in progress
//   state_o - current FSM state (manchester_tx_pkg::state_t encoding)
//
// Handshake: a byte is transferred on a rising edge where valid_i && ready_o.
// ready_o depends only on the state, never on valid_i. The producer may drop
// or change valid_i/data_i at any time; while busy they are ignored.
module manchester_tx
   import manchester_tx_pkg::*;
#(
   parameter int          DIV      = 8,
   parameter logic [7:0]  PREAMBLE = 8'h55
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic       busy_o,
   output logic [1:0] state_o
);

   localparam logic [2:0] BIT_LAST  = 3'(BITS_PER_FIELD - 1);
   localparam logic [1:0] STOP_LAST = 2'(STOP_HALVES - 1);

   state_t     state_q, state_n;
   logic [7:0] sh_q, sh_n;       // field being shifted out, MSB is the current bit
   logic [7:0] data_q, data_n;   // captured byte, loaded into sh_q after the preamble
   logic [2:0] bit_q, bit_n;
   logic [1:0] stop_q, stop_n;
   logic       phase_q, phase_n; // 0 = first half of the bit, 1 = second half
   logic       tx_n, busy_n;
   logic       accept, tick, tick_en;

   assign ready_o = (state_q == IDLE);
   assign accept  = valid_i && ready_o;
   assign state_o = state_q;

   // Held in reset through IDLE, so the half-bit phase restarts at acceptance.
   assign tick_en = (state_q != IDLE);

   half_bit_tick #(.DIV(DIV)) u_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (tick_en),
      .tick_o (tick)
   );

   always_comb begin
      state_n = state_q;
      sh_n    = sh_q;
      data_n  = data_q;
      bit_n   = bit_q;
      stop_n  = stop_q;
      phase_n = phase_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_n = PRE;
               data_n  = data_i;
               sh_n    = PREAMBLE;
               bit_n   = '0;
               stop_n  = '0;
               phase_n = 1'b0;
            end
         end
         PRE, DATA: begin
            if (tick) begin
               phase_n = ~phase_q;
               if (phase_q) begin
                  bit_n = bit_q + 3'd1;
                  sh_n  = {sh_q[6:0], 1'b0};
                  if (bit_q == BIT_LAST) begin
                     if (state_q == PRE) begin
                        state_n = DATA;
                        sh_n    = data_q;
                     end else begin
                        state_n = STOP;
                     end
                  end
               end
            end
         end
         STOP: begin
            if (tick) begin
               stop_n = stop_q + 2'd1;
               if (stop_q == STOP_LAST) begin
                  state_n = IDLE;
                  stop_n  = '0;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Line and busy are computed from next-state values and registered, so
      // they change on the same edge as the state they describe.
      tx_n   = ((state_n == PRE) || (state_n == DATA)) ? line_level(sh_n[7], phase_n) : 1'b0;
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sh_q    <= '0;
         data_q  <= '0;
         bit_q   <= '0;
         stop_q  <= '0;
         phase_q <= 1'b0;
         tx_o    <= 1'b0;
         busy_o  <= 1'b0;
      end else begin
         state_q <= state_n;
         sh_q    <= sh_n;
         data_q  <= data_n;
         bit_q   <= bit_n;
         stop_q  <= stop_n;
         phase_q <= phase_n;
         tx_o    <= tx_n;
         busy_o  <= busy_n;
      end
   end

endmodule

// File: tb/tb_manchester_tx.sv
// tb_manchester_tx
// Bench for manchester_tx: one instance at DIV=2 for most scenarios and one at
// DIV=8 for half-bit width and frame length at the default divider.
module tb_manchester_tx;

   localparam int DIV2 = 2;
   localparam int DIV8 = 8;

   // Half-bit patterns, MSB first, 1 = high half. Bit 0 -> "10", bit 1 -> "01".
   localparam logic [15:0] HB_55 = 16'h9999;
   localparam logic [15:0] HB_A3 = 16'h66A5;
   localparam logic [15:0] HB_00 = 16'hAAAA;
   localparam logic [15:0] HB_FF = 16'h5555;
   localparam logic [15:0] HB_5A = 16'h9966;
   localparam logic [15:0] HB_3C = 16'hA55A;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   logic [7:0] data_2, data_8;
   logic       valid_2, valid_8;
   logic       ready_2, tx_2, busy_2;
   logic       ready_8, tx_8, busy_8;
   logic [1:0] state_2, state_8;

   manchester_tx #(.DIV(DIV2), .PREAMBLE(8'h55)) dut2 (
      .clk_i   (clk),
      .rst_i   (rst),
      .data_i  (data_2),
      .valid_i (valid_2),
      .ready_o (ready_2),
      .tx_o    (tx_2),
      .busy_o  (busy_2),
      .state_o (state_2)
   );

   manchester_tx #(.DIV(DIV8), .PREAMBLE(8'h55)) dut8 (
      .clk_i   (clk),
      .rst_i   (rst),
      .data_i  (data_8),
      .valid_i (valid_8),
      .ready_o (ready_8),
      .tx_o    (tx_8),
      .busy_o  (busy_8),
      .state_o (state_8)
   );

   // ---------------- scoreboard ----------------
   int         total = 0;
   int         bad   = 0;
   logic [0:0] exp2_q[$];
   logic [0:0] exp8_q[$];
   int         len2_q[$];
   int         len8_q[$];

   function automatic void check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic push_frame(input bit w, input logic [15:0] dh);
      logic [31:0] pat;
      int          div;
      pat = {HB_55, dh};
      div = w ? DIV8 : DIV2;
      for (int i = 31; i >= 0; i--) begin
         for (int k = 0; k < div; k++) begin
            if (w) exp8_q.push_back(pat[i]);
            else   exp2_q.push_back(pat[i]);
         end
      end
      for (int k = 0; k < 4 * div; k++) begin
         if (w) exp8_q.push_back(1'b0);
         else   exp2_q.push_back(1'b0);
      end
      if (w) len8_q.push_back(36 * div);
      else   len2_q.push_back(36 * div);
   endtask

   // Returns just after the acceptance edge; t is the cycle count of that edge.
   task automatic wait_accept(input bit w, output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (w ? ready_8 : ready_2) begin
            @(posedge clk);
            #1;
            t  = cyc;
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic send(input bit w, input logic [7:0] b, input logic [15:0] dh, output int t);
      bit ok;
      if (w) begin data_8 = b; valid_8 = 1'b1; end
      else   begin data_2 = b; valid_2 = 1'b1; end
      wait_accept(w, t, ok);
      if (!ok) check("accept_timeout", 0, 1);
      else     push_frame(w, dh);
      if (w) valid_8 = 1'b0;
      else   valid_2 = 1'b0;
   endtask

   task automatic wait_drain(input bit w, input int bound);
      bit done;
      done = 1'b0;
      for (int n = 0; n < bound && !done; n++) begin
         @(negedge clk);
         if (w ? (len8_q.size() == 0) : (len2_q.size() == 0)) done = 1'b1;
      end
      if (!done) check("drain_timeout", 0, 1);
   endtask

   // ---------------- monitors ----------------
   int run2 = 0;
   int run8 = 0;

   always @(negedge clk) begin
      if (busy_2 === 1'b1) begin
         run2++;
         if (exp2_q.size() == 0) check("tx2_unexpected_busy", 1, 0);
         else                    check("tx2", int'(tx_2), int'(exp2_q.pop_front()));
      end else if (run2 > 0) begin
         if (len2_q.size() == 0) check("busy2_len_unexpected", run2, 0);
         else                    check("busy2_len", run2, len2_q.pop_front());
         run2 = 0;
      end
   end

   always @(negedge clk) begin
      if (busy_8 === 1'b1) begin
         run8++;
         if (exp8_q.size() == 0) check("tx8_unexpected_busy", 1, 0);
         else                    check("tx8", int'(tx_8), int'(exp8_q.pop_front()));
      end else if (run8 > 0) begin
         if (len8_q.size() == 0) check("busy8_len_unexpected", run8, 0);
         else                    check("busy8_len", run8, len8_q.pop_front());
         run8 = 0;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int t1, t2;
      bit ok;

      rst     = 1'b1;
      valid_2 = 1'b0;
      valid_8 = 1'b0;
      data_2  = 8'h00;
      data_8  = 8'h00;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst2_outs", int'({tx_2, ready_2, busy_2}), 3'b010);
      check("rst2_state", int'(state_2), 0);
      check("rst8_outs", int'({tx_8, ready_8, busy_8}), 3'b010);
      check("rst8_state", int'(state_8), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // idle with no valid
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("idle2", int'({tx_2, ready_2, busy_2}), 3'b010);
      end

      // single frame 0xA3
      @(posedge clk);
      #1;
      send(1'b0, 8'hA3, HB_A3, t1);
      wait_drain(1'b0, 200);
      @(negedge clk);
      check("post_a3_idle", int'({tx_2, ready_2, busy_2}), 3'b010);

      // back-to-back with valid held: 0x00 then 0xFF
      @(posedge clk);
      #1;
      data_2  = 8'h00;
      valid_2 = 1'b1;
      wait_accept(1'b0, t1, ok);
      if (!ok) check("b2b_accept1_timeout", 0, 1);
      else     push_frame(1'b0, HB_00);
      data_2 = 8'hFF;
      wait_accept(1'b0, t2, ok);
      if (!ok) check("b2b_accept2_timeout", 0, 1);
      else     push_frame(1'b0, HB_FF);
      valid_2 = 1'b0;
      check("b2b_period", t2 - t1, 36 * DIV2 + 1);
      wait_drain(1'b0, 200);

      // reset on busy cycle 40 of a frame
      @(posedge clk);
      #1;
      send(1'b0, 8'h00, HB_00, t1);
      repeat (39) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp2_q.delete();
      len2_q.delete();
      len2_q.push_back(40);
      @(negedge clk);
      check("abort_outs", int'({tx_2, ready_2, busy_2}), 3'b010);
      check("abort_state", int'(state_2), 0);
      wait_drain(1'b0, 20);
      @(posedge clk);
      #1;
      send(1'b0, 8'h3C, HB_3C, t1);
      wait_drain(1'b0, 200);

      // data_i / valid_i churn during a frame of 0x5A
      @(posedge clk);
      #1;
      send(1'b0, 8'h5A, HB_5A, t1);
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         data_2  = 8'($urandom_range(0, 255));
         valid_2 = 1'($urandom_range(0, 1));
      end
      valid_2 = 1'b0;
      wait_drain(1'b0, 200);

      // DIV=8, 0xFF
      @(posedge clk);
      #1;
      send(1'b1, 8'hFF, HB_FF, t1);
      wait_drain(1'b1, 600);
      @(negedge clk);
      check("post_div8_idle", int'({tx_8, ready_8, busy_8}), 3'b010);

      check("exp2_left", exp2_q.size(), 0);
      check("exp8_left", exp8_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
